root_child_scheduler: RTL and testbench
=======================================

ROOT_CHILD_SCHEDULER -- requirements
Module: root_child_scheduler

Purpose: round-robin scheduler that sequences the five child sub-blocks of a root module through one shared start/done slot, with timeout supervision.

Interface -- parameters
REQ-001 N_CHILD, 5, number of child requesters; valid range 2..8.
REQ-002 TIMEOUT, 200, maximum number of cycles in WAIT before a job is abandoned; valid range 2..65535.
REQ-003 IDX_W, 3, width of the child index fields; must satisfy 2**IDX_W >= N_CHILD.

Interface -- ports
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  N_CHILD  per-child job request; level-sensitive.
REQ-007 done  in  N_CHILD  per-child completion; a one-cycle pulse from the child.
REQ-008 grant  out  N_CHILD  one-hot ownership of the shared slot; all-zero when the slot is free.
REQ-009 start  out  N_CHILD  one-hot, one-cycle launch pulse to the granted child.
REQ-010 complete  out  N_CHILD  one-hot, one-cycle pulse when the granted child's job finishes.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 active_idx  out  IDX_W  index of the granted child; 0 when idle.
REQ-013 timeout_err  out  1  one-cycle pulse when a job is abandoned on timeout.
REQ-014 err_idx  out  IDX_W  index of the child that last timed out; holds until the next timeout.
REQ-015 err_cnt  out  8  count of timeouts since reset; saturates at 255.

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, ISSUE, WAIT.
REQ-017 IDLE: if any req bit is high, the block SHALL select the first requesting index searching upward from last_idx+1 modulo N_CHILD, then go to ISSUE.
REQ-018 IDLE with req all-zero: the block SHALL stay in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle; grant and start are both set to the selected one-hot; next state is WAIT.
REQ-020 Latency: req seen in IDLE at cycle t SHALL produce grant and start at cycle t+1.
REQ-021 On entry to WAIT, the timer SHALL clear to 0.
REQ-022 In WAIT, the timer SHALL increment by 1 per cycle; grant stays held; start is 0.
REQ-023 WAIT with done[active_idx] high at cycle d, the block SHALL at d+1:
- assert complete for one cycle,
- clear grant,
- set last_idx to active_idx,
- enter IDLE.
REQ-024 WAIT with the timer equal to TIMEOUT-1 and no matching done, the block SHALL at the next cycle:
- pulse timeout_err,
- load err_idx with active_idx,
- increment err_cnt (saturating at 255),
- clear grant,
- set last_idx to active_idx,
- enter IDLE.
REQ-025 If done[active_idx] and the timeout condition occur in the same cycle, done SHALL win; no timeout is reported.
REQ-026 done bits from non-granted children SHALL be ignored in every state.
REQ-027 A done that arrives during ISSUE SHALL be ignored; the job completes only on a done received in WAIT.
REQ-028 Dropping req after it has been granted SHALL NOT cancel the job.
REQ-029 The grant slot SHALL be non-preemptive; at most one grant bit is high in any cycle.
REQ-030 Consecutive grants SHALL be separated by at least one IDLE cycle.
REQ-031 Arbitration SHALL be fair: with all N_CHILD requests held continuously, grants rotate 0,1,...,N_CHILD-1,0 and so on.
REQ-032 A child whose req is held continuously SHALL be granted within N_CHILD-1 intervening grants.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL be forced to the following values, regardless of the current state (including mid-job):
- state IDLE,
- last_idx N_CHILD-1,
- timer 0,
- grant, start and complete 0,
- busy 0, active_idx 0,
- timeout_err 0, err_idx 0, err_cnt 0.
REQ-034 Reset asserted mid-job SHALL produce no complete and no timeout_err pulse.
REQ-035 The first grant after reset SHALL go to the lowest-index requester.

Verification
REQ-036 Release reset with req=5'b10100 -> grant=5'b00100 and start=5'b00100 one cycle later; start is low on the following cycle.
REQ-037 All req held and each child pulses done 3 cycles after its start -> grant order 0,1,2,3,4,0 and five complete pulses, each matching its grant.
REQ-038 Child 1 granted and never pulses done (TIMEOUT=200) -> timeout_err pulses exactly 201 cycles after start, err_idx=1, err_cnt=1, and the next grant goes to the next requester after index 1.
REQ-039 done[3] pulsed while child 1 is granted -> no effect; done[1] then pulsed in the same cycle as the timer reaching TIMEOUT-1 -> complete[1] pulses and timeout_err stays 0.
REQ-040 rst pulsed during WAIT of child 2 -> grant=0 and busy=0 on the next cycle, no complete pulse; with req=5'b11111 held, child 0 is granted next.
REQ-041 256 forced timeouts -> err_cnt holds at 255.

Source files
------------

// File: rtl/root_child_scheduler.sv
// ---------------------------------------------------------------------------
// root_child_scheduler
//
// Round-robin scheduler that lets the child sub-blocks of a root module take
// turns on one shared start/done slot. Each granted job gets one launch
// pulse and is then supervised until the child reports done or a timeout
// expires. Timeouts are recorded in a sticky index and a saturating count.
//
// Parameters
//   N_CHILD  number of child requesters (2..8)
//   TIMEOUT  cycles a job may spend waiting before it is abandoned (2..65535)
//   IDX_W    width of child index fields, 2**IDX_W >= N_CHILD
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req          per-child level request
//   done         per-child one-cycle completion pulse
//   grant        one-hot owner of the shared slot, zero when free
//   start        one-hot one-cycle launch pulse to the granted child
//   complete     one-hot one-cycle pulse when the owner's job finishes
//   busy         high whenever a job is being issued or awaited
//   active_idx   index of the granted child, zero when idle
//   timeout_err  one-cycle pulse when a job is abandoned
//   err_idx      index of the child that most recently timed out
//   err_cnt      number of timeouts since reset, saturating at 255
// ---------------------------------------------------------------------------
module root_child_scheduler #(
    parameter int N_CHILD = 5,
    parameter int TIMEOUT = 200,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CHILD-1:0] req,
    input  logic [N_CHILD-1:0] done,
    output logic [N_CHILD-1:0] grant,
    output logic [N_CHILD-1:0] start,
    output logic [N_CHILD-1:0] complete,
    output logic               busy,
    output logic [IDX_W-1:0]   active_idx,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   err_idx,
    output logic [7:0]         err_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   last_idx;
    logic [15:0]        timer;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [N_CHILD-1:0] sel_onehot;
    logic [N_CHILD-1:0] req_shift;
    logic               done_hit;
    logic               timer_expired;
    int                 cand;

    // Round-robin pick: scan upward starting just past the previous owner,
    // wrapping modulo N_CHILD, and keep the first requester found.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        req_shift = '0;
        for (int i = 1; i <= N_CHILD; i++) begin
            cand      = (int'(last_idx) + i) % N_CHILD;
            req_shift = req >> cand;
            if (!sel_found && req_shift[0]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    assign sel_onehot = {{(N_CHILD-1){1'b0}}, 1'b1} << sel_idx;

    // grant is the owner's one-hot, so masking done with it picks out only
    // the owner's completion and ignores every other child.
    assign done_hit      = |(done & grant);
    assign timer_expired = (timer == 16'(TIMEOUT - 1));
    assign busy          = (state != IDLE);

    // Main controller: arbitrate in IDLE, launch for one cycle in ISSUE,
    // then supervise the job in WAIT. A done on the same cycle as expiry
    // is treated as a normal completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_idx    <= IDX_W'(N_CHILD - 1);
            timer       <= '0;
            grant       <= '0;
            start       <= '0;
            complete    <= '0;
            active_idx  <= '0;
            timeout_err <= 1'b0;
            err_idx     <= '0;
            err_cnt     <= '0;
        end else begin
            start       <= '0;
            complete    <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state      <= ISSUE;
                        grant      <= sel_onehot;
                        start      <= sel_onehot;
                        active_idx <= sel_idx;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    if (done_hit) begin
                        complete   <= grant;
                        grant      <= '0;
                        last_idx   <= active_idx;
                        active_idx <= '0;
                        state      <= IDLE;
                    end else if (timer_expired) begin
                        timeout_err <= 1'b1;
                        err_idx     <= active_idx;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        grant      <= '0;
                        last_idx   <= active_idx;
                        active_idx <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant      <= '0;
                    active_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_child_scheduler.sv
// ---------------------------------------------------------------------------
// tb_root_child_scheduler
//
// Self-checking bench for root_child_scheduler. A job-level reference model
// (slot owner, job age, previous owner) predicts every output each cycle, and
// directed scenarios pin hand-computed values: reset state, launch latency,
// round-robin order, timeout latency, done-versus-timeout priority, reset
// mid-job and error-count saturation.
// ---------------------------------------------------------------------------
module tb_root_child_scheduler;

    localparam int N_CHILD = 5;
    localparam int TIMEOUT = 200;
    localparam int IDX_W   = 3;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic [N_CHILD-1:0] req  = '0;
    logic [N_CHILD-1:0] done = '0;
    logic [N_CHILD-1:0] grant;
    logic [N_CHILD-1:0] start;
    logic [N_CHILD-1:0] complete;
    logic               busy;
    logic [IDX_W-1:0]   active_idx;
    logic               timeout_err;
    logic [IDX_W-1:0]   err_idx;
    logic [7:0]         err_cnt;

    int tests_run = 0;
    int fails     = 0;

    root_child_scheduler #(
        .N_CHILD (N_CHILD),
        .TIMEOUT (TIMEOUT),
        .IDX_W   (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .start       (start),
        .complete    (complete),
        .busy        (busy),
        .active_idx  (active_idx),
        .timeout_err (timeout_err),
        .err_idx     (err_idx),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N_CHILD-1:0] onehot(input int i);
        logic [N_CHILD-1:0] one;
        one = 1;
        return (i < 0) ? '0 : (one << i);
    endfunction

    function automatic bit bit_of(input logic [N_CHILD-1:0] v, input int i);
        logic [N_CHILD-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int onehot_idx(input logic [N_CHILD-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N_CHILD; i++) begin
            if (v == onehot(i)) r = i;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic report_expired(input string name);
        tests_run++;
        fails++;
        $display("[TB] FAIL %s: event not seen, expected it within its cycle budget at time %0t",
                 name, $time);
    endtask

    task automatic apply_stimulus(input logic r, input logic [N_CHILD-1:0] q,
                                  input logic [N_CHILD-1:0] d);
        rst  = r;
        req  = q;
        done = d;
    endtask

    // Advance negedge by negedge until a launch pulse appears; -1 if none.
    task automatic wait_start(output int idx);
        int k;
        idx = -1;
        k   = 0;
        while (idx < 0 && k < 50) begin
            @(negedge clk);
            k++;
            if (start != '0) idx = onehot_idx(start);
        end
    endtask

    // Reference model: the slot has an owner (or none), each job has an age
    // counted from its launch cycle, and the previous owner seeds the search.
    int                 m_owner   = -1;
    int                 m_age     = 0;
    int                 m_last    = N_CHILD - 1;
    logic [N_CHILD-1:0] m_start   = '0;
    logic [N_CHILD-1:0] m_complete = '0;
    logic               m_terr    = 1'b0;
    int                 m_err_idx = 0;
    int                 m_err_cnt = 0;
    bit                 m_valid   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid    = 1'b1;
                m_owner    = -1;
                m_age      = 0;
                m_last     = N_CHILD - 1;
                m_start    = '0;
                m_complete = '0;
                m_terr     = 1'b0;
                m_err_idx  = 0;
                m_err_cnt  = 0;
            end else if (m_valid) begin
                m_start    = '0;
                m_complete = '0;
                m_terr     = 1'b0;
                if (m_owner < 0) begin
                    for (int i = 1; i <= N_CHILD; i++) begin
                        if (m_owner < 0 && bit_of(req, (m_last + i) % N_CHILD))
                            m_owner = (m_last + i) % N_CHILD;
                    end
                    if (m_owner >= 0) begin
                        m_age   = 0;
                        m_start = onehot(m_owner);
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (bit_of(done, m_owner)) begin
                    m_complete = onehot(m_owner);
                    m_last     = m_owner;
                    m_owner    = -1;
                end else if (m_age == TIMEOUT) begin
                    m_terr    = 1'b1;
                    m_err_idx = m_owner;
                    if (m_err_cnt < 255) m_err_cnt++;
                    m_last    = m_owner;
                    m_owner   = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // Compare every output with the model in the middle of each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check_output("model_grant", 32'(grant), 32'(onehot(m_owner)));
                check_output("model_start", 32'(start), 32'(m_start));
                check_output("model_complete", 32'(complete), 32'(m_complete));
                check_output("model_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
                check_output("model_active_idx", 32'(active_idx),
                             (m_owner >= 0) ? 32'(m_owner) : 32'd0);
                check_output("model_timeout_err", 32'(timeout_err), 32'(m_terr));
                check_output("model_err_idx", 32'(err_idx), 32'(m_err_idx));
                check_output("model_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected $finish before time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int n;
        int k;
        int ncomp;
        bit seen;
        bit ok;

        // Reset state, then launch latency with two requesters.
        @(negedge clk);
        @(negedge clk);
        check_output("reset_grant", 32'(grant), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_start", 32'(start), 32'd0);
        check_output("reset_active_idx", 32'(active_idx), 32'd0);
        check_output("reset_err_cnt", 32'(err_cnt), 32'd0);
        apply_stimulus(1'b0, 5'b10100, 5'b00000);
        @(negedge clk);
        check_output("first_grant", 32'(grant), 32'b00100);
        check_output("first_start", 32'(start), 32'b00100);
        check_output("first_active_idx", 32'(active_idx), 32'd2);
        @(negedge clk);
        check_output("start_drops", 32'(start), 32'd0);
        check_output("grant_held", 32'(grant), 32'b00100);
        apply_stimulus(1'b0, 5'b00000, 5'b00100);
        @(negedge clk);
        check_output("first_complete", 32'(complete), 32'b00100);
        check_output("grant_released", 32'(grant), 32'd0);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);
        @(negedge clk);
        check_output("complete_one_cycle", 32'(complete), 32'd0);

        // All requesting, done three cycles after each launch.
        apply_stimulus(1'b1, 5'b11111, 5'b00000);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b11111, 5'b00000);
        ncomp = 0;
        for (int j = 0; j < 6; j++) begin
            wait_start(idx);
            check_output("rr_order", 32'(idx), 32'(j % N_CHILD));
            repeat (3) @(negedge clk);
            apply_stimulus(1'b0, 5'b11111, onehot(idx));
            @(negedge clk);
            check_output("rr_complete", 32'(complete), 32'(onehot(j % N_CHILD)));
            if (j < 5 && complete == onehot(j % N_CHILD)) ncomp++;
            apply_stimulus(1'b0, (j == 5) ? 5'b00000 : 5'b11111, 5'b00000);
        end
        check_output("rr_complete_count", 32'(ncomp), 32'd5);

        // Child 1 never answers; child 3 is waiting behind it.
        apply_stimulus(1'b1, 5'b00000, 5'b00000);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b01010, 5'b00000);
        wait_start(idx);
        check_output("timeout_owner", 32'(idx), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (timeout_err) seen = 1'b1;
        end
        if (!seen) report_expired("timeout_pulse");
        check_output("timeout_latency", 32'(n), 32'd201);
        check_output("timeout_err_idx", 32'(err_idx), 32'd1);
        check_output("timeout_err_cnt", 32'(err_cnt), 32'd1);
        check_output("timeout_grant_clear", 32'(grant), 32'd0);
        wait_start(idx);
        check_output("after_timeout_owner", 32'(idx), 32'd3);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, onehot(3));
        @(negedge clk);
        check_output("child3_complete", 32'(complete), 32'b01000);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);

        // Stray and early done pulses, then done exactly at expiry.
        apply_stimulus(1'b0, 5'b00010, 5'b00000);
        wait_start(idx);
        check_output("race_owner", 32'(idx), 32'd1);
        apply_stimulus(1'b0, 5'b00010, 5'b00010);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);
        check_output("issue_done_ignored", 32'(complete), 32'd0);
        check_output("issue_done_grant", 32'(grant), 32'b00010);
        repeat (4) @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, 5'b01000);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);
        check_output("foreign_done_grant", 32'(grant), 32'b00010);
        check_output("foreign_done_complete", 32'(complete), 32'd0);
        repeat (194) @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, 5'b00010);
        @(negedge clk);
        check_output("race_complete", 32'(complete), 32'b00010);
        check_output("race_no_timeout", 32'(timeout_err), 32'd0);
        check_output("race_err_cnt", 32'(err_cnt), 32'd1);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);

        // Reset in the middle of child 2's job.
        apply_stimulus(1'b0, 5'b00100, 5'b00000);
        wait_start(idx);
        check_output("reset_mid_owner", 32'(idx), 32'd2);
        repeat (2) @(negedge clk);
        apply_stimulus(1'b1, 5'b11111, 5'b00000);
        @(negedge clk);
        check_output("reset_mid_grant", 32'(grant), 32'd0);
        check_output("reset_mid_busy", 32'(busy), 32'd0);
        check_output("reset_mid_complete", 32'(complete), 32'd0);
        check_output("reset_mid_timeout", 32'(timeout_err), 32'd0);
        apply_stimulus(1'b0, 5'b11111, 5'b00000);
        wait_start(idx);
        check_output("after_reset_owner", 32'(idx), 32'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 5'b00000, 5'b00001);
        @(negedge clk);
        check_output("child0_complete", 32'(complete), 32'b00001);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);

        // Force 256 timeouts on child 0 and watch the counter saturate.
        apply_stimulus(1'b0, 5'b00001, 5'b00000);
        ok = 1'b1;
        for (int t = 0; t < 256; t++) begin
            if (ok) begin
                k = 0;
                seen = 1'b0;
                while (!seen && k < 300) begin
                    @(negedge clk);
                    k++;
                    if (timeout_err) seen = 1'b1;
                end
                if (!seen) begin
                    report_expired("saturation_timeout");
                    ok = 1'b0;
                end
                if (t == 254) check_output("err_cnt_255th", 32'(err_cnt), 32'd255);
                if (t == 255) apply_stimulus(1'b0, 5'b00000, 5'b00000);
            end
        end
        check_output("err_cnt_saturated", 32'(err_cnt), 32'd255);
        check_output("sat_err_idx", 32'(err_idx), 32'd0);
        apply_stimulus(1'b0, 5'b00000, 5'b00000);
        repeat (3) @(negedge clk);
        check_output("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
